// File: rtl/nixie_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nixie_scan_ctrl
// Brief    : Time-multiplexed nixie scan controller with bus-written display
//            buffer and blanking dead time. Optional blink mask: NIXIE_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nixie_scan_ctrl #(
    parameter int NUM_BYTES = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_BIT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic [2:0]           wr_addr,
    input  logic [7:0]           wr_data,
    output logic                 wr_ack,
    output logic [7:0]           byte_o,
    output logic [NUM_BYTES-1:0] sel_o,
    output logic [1:0]           slot_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] c_show_last  = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [1:0]       c_last_idx   = 2'(NUM_BYTES - 1);
    localparam logic [2:0]       c_mask_addr  = 3'd4;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [1:0]                  r_idx;
    logic [1:0]                  w_idx_nxt;
    logic [7:0]                  r_frame;
    logic [7:0]                  w_frame_nxt;
    logic [NUM_BYTES-1:0][7:0]   r_buf;
    logic [7:0]                  r_byte;
    logic                        r_ack;
    logic                        w_wr_en;
    logic                        w_blink_off;

    // A request is only taken while no acknowledge is outstanding.
    assign w_wr_en = wr_req & ~r_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == c_show_last) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == c_last_idx) begin
                        w_idx_nxt   = '0;
                        w_frame_nxt = r_frame + 8'd1;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_wr_en;
            if (w_wr_en) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (wr_addr == 3'(i)) begin
                        r_buf[i] <= wr_data;
                    end
                end
            end
        end
    end

    // Registered from the current index, so a write to the active byte shows up one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte <= '0;
        end else begin
            r_byte <= r_buf[r_idx];
        end
    end

`ifdef NIXIE_BLINK_EN
    logic [NUM_BYTES-1:0] r_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= '0;
        end else if (w_wr_en && wr_addr == c_mask_addr) begin
            r_mask <= wr_data[NUM_BYTES-1:0];
        end
    end

    assign w_blink_off = r_mask[r_idx] & r_frame[BLINK_BIT];
`else
    // Frame counter still runs; its blink phase simply has nothing to gate.
    assign w_blink_off = r_frame[BLINK_BIT] & 1'b0;
`endif

    always_comb begin
        sel_o = '0;
        if (r_state == ST_SHOW && !w_blink_off) begin
            sel_o = NUM_BYTES'(1) << r_idx;
        end
    end

    assign wr_ack = r_ack;
    assign byte_o = r_byte;
    assign slot_o = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_nixie_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nixie_scan_ctrl
// Brief    : Directed self-checking bench for nixie_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nixie_scan_ctrl;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       wr_req  = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_ack;
    logic [7:0] byte_o;
    logic [3:0] sel_o;
    logic [1:0] slot_o;

    int         n_pass  = 0;
    int         n_total = 0;
    int         n_edge  = 0;
    int         pulses;
    logic [7:0] m_buf [4];
    logic [3:0] m_mask;

    nixie_scan_ctrl #(
        .NUM_BYTES (4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .BLINK_BIT (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .byte_o  (byte_o),
        .sel_o   (sel_o),
        .slot_o  (slot_o)
    );

    always #5 clk = ~clk;

    // Edges since reset release: slot position = n%8, slot = (n/8)%4, frame = n/32.
    always @(posedge clk or negedge rst) begin
        if (!rst) n_edge <= 0;
        else      n_edge <= n_edge + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] exp_sel(input int n);
        int   p;
        int   s;
        int   f;
        logic sup;
        p   = n % 8;
        s   = (n / 8) % 4;
        f   = (n / 32) % 256;
        sup = 1'b0;
`ifdef NIXIE_BLINK_EN
        sup = m_mask[s] && f[5];
`endif
        return (p >= 2 && !sup) ? 4'(1 << s) : 4'b0000;
    endfunction

    task automatic run_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("sel", 32'(sel_o), 32'(exp_sel(n_edge)));
            chk("slot", 32'(slot_o), (n_edge / 8) % 4);
            if (n_edge % 8 >= 1) chk("byte", 32'(byte_o), 32'(m_buf[(n_edge / 8) % 4]));
        end
    endtask

    task automatic wait_slot(input int slot, input int pos);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((n_edge / 8) % 4 == slot && n_edge % 8 == pos) return;
        end
        chk("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        chk("wr_ack_hi", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        if (addr < 3'd4) m_buf[addr[1:0]] = data;
        if (addr == 3'd4) m_mask = data[3:0];
        @(negedge clk);
        chk("wr_ack_lo", 32'(wr_ack), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"},  32'(sel_o),  32'd0);
        chk({tag, "_slot"}, 32'(slot_o), 32'd0);
        chk({tag, "_byte"}, 32'(byte_o), 32'd0);
        chk({tag, "_ack"},  32'(wr_ack), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;
        m_mask = 4'h0;

        #1;
        chk_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b1;
        chk("rel_sel", 32'(sel_o), 32'd0);

        // Idle scan across a frame wrap.
        run_check(40);

        // Buffer write shows only in its own slot; out-of-range write is acked and ignored.
        do_write(3'd2, 8'h3C);
        do_write(3'd6, 8'h99);
        run_check(32);

        // Held request: accepted every other cycle.
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'hA5;
        pulses  = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("hold_ack%0d", i), 32'(wr_ack), 32'(i % 2));
            pulses += int'(wr_ack);
        end
        wr_req   = 1'b0;
        chk("hold_pulses", pulses, 32'd2);
        m_buf[0] = 8'hA5;
        run_check(32);

        // Write to the byte currently on display.
        wait_slot(1, 3);
        wr_req  = 1'b1;
        wr_addr = 3'd1;
        wr_data = 8'h11;
        @(negedge clk);
        wr_req = 1'b0;
        chk("act_ack", 32'(wr_ack), 32'd1);
        chk("act_byte_old", 32'(byte_o), 32'h00);
        chk("act_sel0", 32'(sel_o), 32'(exp_sel(n_edge)));
        @(negedge clk);
        chk("act_byte_new", 32'(byte_o), 32'h11);
        chk("act_sel1", 32'(sel_o), 32'b0010);
        m_buf[1] = 8'h11;
        run_check(40);

        // Asynchronous reset in the middle of slot 3's SHOW.
        do_write(3'd3, 8'h77);
        run_check(32);
        wait_slot(3, 4);
        chk("pre_rst_sel", 32'(sel_o), 32'b1000);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async");
        for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;
        m_mask = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        chk("rel2_sel", 32'(sel_o), 32'd0);
        run_check(40);

        // Blink mask on slot 0 over 64 frames.
        do_write(3'd4, 8'h01);
        run_check(64 * 32 + 8 - n_edge);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
